// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler: arbitrates NREQ requesters onto the single register-file
// write port (fixed priority with aging) and drives registered MemtoReg/address/RegWrite.
module wb_port_scheduler #(
  parameter int NREQ     = 3,
  parameter int SEL_W    = 4,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SEL_W-1:0]   req_sel,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  output logic [NREQ-1:0]         req_ready,
  output logic [SEL_W-1:0]        mem_to_reg,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic                    reg_write,
  output logic                    sel_err,
  output logic                    busy
);

  localparam int                 CNT_W          = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX        = CNT_W'(MAX_WAIT);
  localparam logic [SEL_W-1:0]   SEL_LAST_LEGAL = SEL_W'(9);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt [NREQ];
  logic [NREQ-1:0]    promoted;
  logic [NREQ-1:0]    grant;
  logic               granted;
  logic [SEL_W-1:0]   grant_sel;
  logic [ADDR_W-1:0]  grant_addr;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    promoted = '0;
    grant    = '0;
    for (int i = 0; i < NREQ; i++)
      promoted[i] = req_valid[i] && (wait_cnt[i] == CNT_MAX);
    // Gating with reset_n drops any grant in a cycle where reset is sampled.
    if (reset_n && !hold) begin
      if (|promoted) grant = promoted & (~promoted + NREQ'(1));
      else           grant = req_valid & (~req_valid + NREQ'(1));
    end
  end

  always_comb begin
    grant_sel  = '0;
    grant_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_sel  = req_sel[i*SEL_W +: SEL_W];
        grant_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign granted   = |grant;
  assign req_ready = grant;
  assign busy      = (state != IDLE);

  // NOTE: all state here updates with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_to_reg <= '0;
      reg_addr   <= '0;
      reg_write  <= 1'b0;
      sel_err    <= 1'b0;
      // NOTE: the wait counters are a handful of flops, not a RAM, so resetting them is cheap and required.
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hold) begin
          if (!req_valid[i] || grant[i])  wait_cnt[i] <= '0;
          else if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end

      // Writes to $0 are consumed but never raise reg_write.
      reg_write <= granted && (grant_addr != '0);
      if (granted) begin
        mem_to_reg <= grant_sel;
        reg_addr   <= grant_addr;
        if (grant_sel > SEL_LAST_LEGAL) sel_err <= 1'b1;
      end

      case (state)
        IDLE, WRITE, HOLD: begin
          if (hold)         state <= HOLD;
          else if (granted) state <= WRITE;
          else              state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Self-checking bench for wb_port_scheduler: directed vector table, aging and reset
// sequences, then randomized traffic against a rule-level reference model.
module tb_wb_port_scheduler;

  localparam int NREQ     = 3;
  localparam int SEL_W    = 4;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   hold;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*SEL_W-1:0]  req_sel;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic [SEL_W-1:0]       mem_to_reg;
  logic [ADDR_W-1:0]      reg_addr;
  logic                   reg_write;
  logic                   sel_err;
  logic                   busy;

  wb_port_scheduler #(
    .NREQ(NREQ), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hold(hold),
    .req_valid(req_valid), .req_sel(req_sel), .req_addr(req_addr),
    .req_ready(req_ready), .mem_to_reg(mem_to_reg), .reg_addr(reg_addr),
    .reg_write(reg_write), .sel_err(sel_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] v;
    logic [3:0] s0, s1, s2;
    logic [4:0] a0, a1, a2;
    logic       h;
    logic [2:0] er;
    logic       ew;
    logic [3:0] em;
    logic [4:0] ea;
    logic       ee;
    logic       eb;
  } vec_t;

  vec_t vecs [16];

  // Reference model state
  int         m_wait [NREQ];
  logic       m_write, m_err, m_busy;
  logic [3:0] m_m2r;
  logic [4:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [3:0] s0, s1, s2,
                       input logic [4:0] a0, a1, a2, input logic h);
    req_valid = v;
    req_sel   = {s2, s1, s0};
    req_addr  = {a2, a1, a0};
    hold      = h;
  endtask

  // Called one time unit after a rising edge: checks ready mid-cycle, then the registered outputs.
  task automatic step_check(input string tag, input logic [2:0] er, input logic ew,
                            input logic [3:0] em, input logic [4:0] ea,
                            input logic ee, input logic eb);
    #3;
    check({tag, " ready"}, req_ready, er);
    @(posedge clk);
    #1;
    check({tag, " reg_write"}, reg_write, ew);
    check({tag, " mem_to_reg"}, mem_to_reg, em);
    check({tag, " reg_addr"}, reg_addr, ea);
    check({tag, " sel_err"}, sel_err, ee);
    check({tag, " busy"}, busy, eb);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    m_write = 0; m_err = 0; m_busy = 0; m_m2r = '0; m_addr = '0;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    drive(3'b111, 4'd1, 4'd2, 4'd3, 5'd4, 5'd5, 5'd6, 1'b0);
    for (int c = 0; c < 2; c++)
      step_check($sformatf("%s_c%0d", tag, c), 3'b000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(3'b000, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    model_clear();
  endtask

  // Winner by the arbitration rules: promoted requesters first, then plain priority.
  function automatic int model_grant(input logic [2:0] v, input logic h, input logic rst_n);
    if (!rst_n || h) return -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && m_wait[i] == MAX_WAIT) return i;
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input logic [2:0] v, input logic [3:0] s [NREQ],
                              input logic [4:0] a [NREQ], input logic h,
                              input logic rst_n, input int g);
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (h)                   m_wait[i] = m_wait[i];
      else if (!v[i] || g == i) m_wait[i] = 0;
      else                     m_wait[i] = (m_wait[i] < MAX_WAIT) ? m_wait[i] + 1 : MAX_WAIT;
    end
    m_write = 0;
    if (g >= 0) begin
      m_m2r   = s[g];
      m_addr  = a[g];
      m_write = (a[g] != 0);
      if (s[g] > 9) m_err = 1;
    end
    m_busy = h || (g >= 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b010, 4'd0, 4'd2, 4'd0, 5'd0, 5'd8, 5'd0, 1'b0,  3'b010, 1'b1, 4'd2,  5'd8,  1'b0, 1'b1};
    vecs[1]  = '{3'b000, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0,  3'b000, 1'b0, 4'd2,  5'd8,  1'b0, 1'b0};
    vecs[2]  = '{3'b101, 4'd0, 4'd0, 4'd4, 5'd3, 5'd0, 5'd9, 1'b0,  3'b001, 1'b1, 4'd0,  5'd3,  1'b0, 1'b1};
    vecs[3]  = '{3'b100, 4'd0, 4'd0, 4'd4, 5'd0, 5'd0, 5'd9, 1'b0,  3'b100, 1'b1, 4'd4,  5'd9,  1'b0, 1'b1};
    vecs[4]  = '{3'b000, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0,  3'b000, 1'b0, 4'd4,  5'd9,  1'b0, 1'b0};
    vecs[5]  = '{3'b001, 4'd5, 4'd0, 4'd0, 5'd6, 5'd0, 5'd0, 1'b0,  3'b001, 1'b1, 4'd5,  5'd6,  1'b0, 1'b1};
    vecs[6]  = '{3'b010, 4'd0, 4'd3, 4'd0, 5'd0, 5'd12, 5'd0, 1'b1, 3'b000, 1'b0, 4'd5,  5'd6,  1'b0, 1'b1};
    vecs[7]  = '{3'b010, 4'd0, 4'd3, 4'd0, 5'd0, 5'd12, 5'd0, 1'b1, 3'b000, 1'b0, 4'd5,  5'd6,  1'b0, 1'b1};
    vecs[8]  = '{3'b010, 4'd0, 4'd3, 4'd0, 5'd0, 5'd12, 5'd0, 1'b1, 3'b000, 1'b0, 4'd5,  5'd6,  1'b0, 1'b1};
    vecs[9]  = '{3'b010, 4'd0, 4'd3, 4'd0, 5'd0, 5'd12, 5'd0, 1'b0, 3'b010, 1'b1, 4'd3,  5'd12, 1'b0, 1'b1};
    vecs[10] = '{3'b000, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0,  3'b000, 1'b0, 4'd3,  5'd12, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 4'd1, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0,  3'b001, 1'b0, 4'd1,  5'd0,  1'b0, 1'b1};
    vecs[12] = '{3'b001, 4'd11, 4'd0, 4'd0, 5'd5, 5'd0, 5'd0, 1'b0, 3'b001, 1'b1, 4'd11, 5'd5,  1'b1, 1'b1};
    vecs[13] = '{3'b000, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0,  3'b000, 1'b0, 4'd11, 5'd5,  1'b1, 1'b0};
    vecs[14] = '{3'b100, 4'd0, 4'd0, 4'd7, 5'd0, 5'd0, 5'd31, 1'b0, 3'b100, 1'b1, 4'd7,  5'd31, 1'b1, 1'b1};
    vecs[15] = '{3'b000, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0,  3'b000, 1'b0, 4'd7,  5'd31, 1'b1, 1'b0};

    #1;
    do_reset("reset0");

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].v, vecs[k].s0, vecs[k].s1, vecs[k].s2,
            vecs[k].a0, vecs[k].a1, vecs[k].a2, vecs[k].h);
      step_check($sformatf("vec%0d", k), vecs[k].er, vecs[k].ew,
                 vecs[k].em, vecs[k].ea, vecs[k].ee, vecs[k].eb);
    end

    // Aging: ch0 streams fresh payloads, ch2 waits and wins on its 5th blocked cycle.
    do_reset("reset1");
    for (int k = 1; k <= 6; k++) begin
      drive(3'b101, 4'd1, 4'd0, 4'd6, 5'(k), 5'd0, 5'd20, 1'b0);
      if (k == 5) step_check($sformatf("aging%0d", k), 3'b100, 1'b1, 4'd6, 5'd20, 1'b0, 1'b1);
      else        step_check($sformatf("aging%0d", k), 3'b001, 1'b1, 4'd1, 5'(k), 1'b0, 1'b1);
    end

    // Randomized traffic against the reference model.
    do_reset("reset2");
    begin
      logic [2:0] v;
      logic [3:0] s [NREQ];
      logic [4:0] a [NREQ];
      logic       pend [NREQ];
      logic       h, rst_n;
      int         g;
      for (int i = 0; i < NREQ; i++) begin pend[i] = 0; s[i] = '0; a[i] = '0; end
      for (int n = 0; n < 400; n++) begin
        rst_n = ($urandom_range(0, 49) != 0);
        h     = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < NREQ; i++) begin
          if (pend[i]) begin
            v[i] = ($urandom_range(0, 7) != 0);
          end else begin
            v[i] = $urandom_range(0, 1) != 0;
            s[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            a[i] = 5'($urandom_range(0, 31));
          end
        end
        reset_n   = rst_n;
        req_valid = v;
        req_sel   = {s[2], s[1], s[0]};
        req_addr  = {a[2], a[1], a[0]};
        hold      = h;
        g = model_grant(v, h, rst_n);
        #3;
        check($sformatf("rand%0d ready", n), req_ready, (g >= 0) ? (3'b001 << g) : 3'b000);
        @(posedge clk);
        model_update(v, s, a, h, rst_n, g);
        #1;
        check($sformatf("rand%0d reg_write", n), reg_write, m_write);
        check($sformatf("rand%0d mem_to_reg", n), mem_to_reg, m_m2r);
        check($sformatf("rand%0d reg_addr", n), reg_addr, m_addr);
        check($sformatf("rand%0d sel_err", n), sel_err, m_err);
        check($sformatf("rand%0d busy", n), busy, m_busy);
        for (int i = 0; i < NREQ; i++) pend[i] = rst_n && v[i] && (g != i);
      end
    end

    // Reset after traffic must clear the sticky error and all outputs.
    do_reset("reset3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
